// File: rtl/mtsp_if_fetch_pkg.sv
// Shared definitions for the MTSP instruction fetch stage.
package mtsp_if_fetch_pkg;

  localparam int unsigned UINST_W   = 32;
  localparam int unsigned UINSTX4_W = 4 * UINST_W;

  // All-ones bundle marks an empty slot (bubble) towards ID_0.
  localparam logic [UINSTX4_W-1:0] UINSTX4_BUBBLE = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/mtsp_if_fetch_if.sv
// Control, instruction-memory and ID_0 signals of the fetch stage.
interface mtsp_if_fetch_if #(
  parameter int unsigned PC_WIDTH = 16
);

  logic                                      EN;
  logic                                      STALL;
  logic                                      BR_EN;
  logic [PC_WIDTH-1:0]                       BR_PC;
  logic                                      IMEM_REQ;
  logic [PC_WIDTH-1:0]                       IMEM_ADDR;
  logic                                      IMEM_GRANT;
  logic                                      IMEM_RVALID;
  logic [mtsp_if_fetch_pkg::UINSTX4_W-1:0]   IMEM_RDATA;
  logic [PC_WIDTH-1:0]                       PC_OUT;
  logic [mtsp_if_fetch_pkg::UINSTX4_W-1:0]   UINSTx4_OUT;
  logic                                      IDLE;

  // Fetch stage side.
  modport master (
    input  EN, STALL, BR_EN, BR_PC, IMEM_GRANT, IMEM_RVALID, IMEM_RDATA,
    output IMEM_REQ, IMEM_ADDR, PC_OUT, UINSTx4_OUT, IDLE
  );

  // Environment side: core control, instruction memory and decode.
  modport slave (
    output EN, STALL, BR_EN, BR_PC, IMEM_GRANT, IMEM_RVALID, IMEM_RDATA,
    input  IMEM_REQ, IMEM_ADDR, PC_OUT, UINSTx4_OUT, IDLE
  );

endinterface

// File: rtl/mtsp_if_fifo.sv
// Prefetch FIFO of {PC, bundle} pairs; pointers carry an extra wrap bit.
module mtsp_if_fifo
  import mtsp_if_fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 16,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [PC_WIDTH-1:0]       push_pc,
  input  logic [UINSTX4_W-1:0]      push_data,
  output logic [PC_WIDTH-1:0]       head_pc,
  output logic [UINSTX4_W-1:0]      head_data,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PC_WIDTH-1:0]  pc_mem   [DEPTH];
  logic [UINSTX4_W-1:0] data_mem [DEPTH];
  logic [AW:0]          wr_ptr_q;
  logic [AW:0]          rd_ptr_q;

  // Pointer update; flush empties the FIFO and wins over push/pop.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  // Entry storage, no reset needed since occupancy is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      pc_mem[wr_ptr_q[AW-1:0]]   <= push_pc;
      data_mem[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

  assign head_pc   = pc_mem[rd_ptr_q[AW-1:0]];
  assign head_data = data_mem[rd_ptr_q[AW-1:0]];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign count     = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/mtsp_if_fetch.sv
// MTSP instruction fetch: PC, bundle requests, prefetch buffer, ID_0 output register.
module mtsp_if_fetch
  import mtsp_if_fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH   = 16,
  parameter int unsigned         FIFO_DEPTH = 2,
  parameter logic [PC_WIDTH-1:0] BOOT_PC    = '0
) (
  input logic            CLK,
  input logic            nRST,
  mtsp_if_fetch_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e         state_q, state_d;
  logic [PC_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]        outstanding_q, outstanding_d;
  logic [CW-1:0]        discard_q, discard_d;
  logic [PC_WIDTH-1:0]  pc_out_q;
  logic [UINSTX4_W-1:0] uinst_out_q;

  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [PC_WIDTH-1:0]  fifo_pc;
  logic [UINSTX4_W-1:0] fifo_data;
  logic [CW:0]          in_use;
  logic                 req, grant, resp, push, pop;

  // Slots already claimed: buffered bundles plus reads still in flight.
  assign in_use = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign req    = (state_q == S_RUN) && (in_use < (CW + 1)'(FIFO_DEPTH));
  assign grant  = req && bus.IMEM_GRANT;
  // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
  assign resp   = bus.IMEM_RVALID && (outstanding_q != '0);
  assign push   = resp && (discard_q == '0) && !bus.BR_EN;
  assign pop    = !bus.STALL && !bus.BR_EN && !fifo_empty;

  mtsp_if_fifo #(
    .PC_WIDTH (PC_WIDTH),
    .DEPTH    (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (push),
    .pop       (pop),
    .flush     (bus.BR_EN),
    .push_pc   (fetch_pc_q - PC_WIDTH'(outstanding_q)),
    .push_data (bus.IMEM_RDATA),
    .head_pc   (fifo_pc),
    .head_data (fifo_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state for FSM, fetch PC and in-flight/discard counters.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    unique case ({grant, resp})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (bus.BR_EN) begin
      // Everything still in flight after this cycle belongs to the old path.
      discard_d  = outstanding_d;
      fetch_pc_d = bus.BR_PC;
    end else begin
      if (resp && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (grant) fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
    end

    unique case (state_q)
      S_IDLE:  if (bus.EN) state_d = S_RUN;
      S_RUN:   if (!bus.EN) state_d = S_DRAIN;
      S_DRAIN: begin
        if (bus.EN)                   state_d = S_RUN;
        else if (outstanding_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= BOOT_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // ID_0 output register: redirect forces a bubble, stall holds, else pop or bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_out_q    <= '0;
      uinst_out_q <= UINSTX4_BUBBLE;
    end else if (bus.BR_EN) begin
      uinst_out_q <= UINSTX4_BUBBLE;
    end else if (!bus.STALL) begin
      if (pop) begin
        pc_out_q    <= fifo_pc;
        uinst_out_q <= fifo_data;
      end else begin
        uinst_out_q <= UINSTX4_BUBBLE;
      end
    end
  end

  assign bus.IMEM_REQ    = req;
  assign bus.IMEM_ADDR   = fetch_pc_q;
  assign bus.PC_OUT      = pc_out_q;
  assign bus.UINSTx4_OUT = uinst_out_q;
  assign bus.IDLE        = (state_q == S_IDLE) && (outstanding_q == '0);

endmodule

// File: tb/tb_mtsp_if_fetch.sv
// Scoreboard bench for mtsp_if_fetch: memory model plus cycle model of the fetch stage.
module tb_mtsp_if_fetch;
  import mtsp_if_fetch_pkg::*;

  localparam int unsigned PW = 16;

  typedef struct {
    logic [PW-1:0] addr;
    int            due;
    bit            killed;
  } mreq_t;

  typedef struct {
    logic [PW-1:0]        pc;
    logic [UINSTX4_W-1:0] data;
  } ent_t;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  mtsp_if_fetch_if #(.PC_WIDTH(PW)) bus ();

  mtsp_if_fetch #(
    .PC_WIDTH   (PW),
    .FIFO_DEPTH (2),
    .BOOT_PC    (16'h0000)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  mreq_t                pipe[$];    // reads granted, response not yet returned
  ent_t                 fifo_m[$];  // expected bundles waiting for ID_0
  fetch_state_e         state_m;
  logic [PW-1:0]        fpc_m;
  logic [PW-1:0]        pc_m;
  logic [UINSTX4_W-1:0] uinst_m;
  int                   cyc, lat, gnt_pct;
  int                   checks, errors;

  function automatic logic [UINSTX4_W-1:0] bundle(input logic [PW-1:0] a);
    return {a, 16'h1234, ~a, 16'h5678, a ^ 16'hBEEF, 16'h0F0F, a[7:0], a[15:8], 16'h0000};
  endfunction

  task automatic check_eq(input string tag, input logic [UINSTX4_W-1:0] obs,
                          input logic [UINSTX4_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    state_m = S_IDLE;
    fpc_m   = '0;
    pc_m    = '0;
    uinst_m = UINSTX4_BUBBLE;
    pipe.delete();
    fifo_m.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   bus.IMEM_REQ,    1'b0);
    check_eq({tag, "_addr"},  bus.IMEM_ADDR,   16'h0000);
    check_eq({tag, "_pc"},    bus.PC_OUT,      16'h0000);
    check_eq({tag, "_uinst"}, bus.UINSTx4_OUT, UINSTX4_BUBBLE);
    check_eq({tag, "_idle"},  bus.IDLE,        1'b1);
  endtask

  // One clock: check request side before the edge, advance model, check outputs after.
  task automatic step();
    bit    req_e, grant, resp, pop;
    int    in_use;
    mreq_t m;
    ent_t  e;
    @(negedge CLK);
    in_use = pipe.size() + fifo_m.size();
    req_e  = (state_m == S_RUN) && (in_use < 2);
    check_eq("imem_req",  bus.IMEM_REQ,  req_e);
    check_eq("imem_addr", bus.IMEM_ADDR, fpc_m);
    check_eq("idle",      bus.IDLE,      (state_m == S_IDLE) && (pipe.size() == 0));

    grant = req_e && bus.IMEM_GRANT;
    resp  = bus.IMEM_RVALID && (pipe.size() > 0);
    pop   = !bus.STALL && !bus.BR_EN && (fifo_m.size() > 0);

    if (bus.BR_EN) begin
      uinst_m = UINSTX4_BUBBLE;
    end else if (!bus.STALL) begin
      if (pop) begin
        pc_m    = fifo_m[0].pc;
        uinst_m = fifo_m[0].data;
      end else begin
        uinst_m = UINSTX4_BUBBLE;
      end
    end

    if (bus.BR_EN) begin
      fifo_m.delete();
    end else begin
      if (pop) void'(fifo_m.pop_front());
      if (resp && !pipe[0].killed) begin
        e.pc   = pipe[0].addr;
        e.data = bundle(pipe[0].addr);
        fifo_m.push_back(e);
      end
    end

    if (resp) void'(pipe.pop_front());
    if (grant) begin
      m.addr   = fpc_m;
      m.due    = cyc + lat;
      m.killed = 1'b0;
      pipe.push_back(m);
    end
    if (bus.BR_EN) begin
      foreach (pipe[i]) pipe[i].killed = 1'b1;
      fpc_m = bus.BR_PC;
    end else if (grant) begin
      fpc_m = fpc_m + 16'h0001;
    end

    case (state_m)
      S_IDLE:  if (bus.EN) state_m = S_RUN;
      S_RUN:   if (!bus.EN) state_m = S_DRAIN;
      default: begin
        if (bus.EN)                state_m = S_RUN;
        else if (pipe.size() == 0) state_m = S_IDLE;
      end
    endcase

    @(posedge CLK);
    #1;
    cyc++;
    check_eq("pc_out",    bus.PC_OUT,      pc_m);
    check_eq("uinst_out", bus.UINSTx4_OUT, uinst_m);

    if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      bus.IMEM_RVALID = 1'b1;
      bus.IMEM_RDATA  = bundle(pipe[0].addr);
    end else begin
      bus.IMEM_RVALID = 1'b0;
      bus.IMEM_RDATA  = '1;
    end
    bus.IMEM_GRANT = ($urandom_range(99) < gnt_pct);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    lat     = 1;
    gnt_pct = 100;
    nRST    = 1'b1;
    bus.EN = 1'b0; bus.STALL = 1'b0; bus.BR_EN = 1'b0; bus.BR_PC = '0;
    bus.IMEM_GRANT = 1'b0; bus.IMEM_RVALID = 1'b0; bus.IMEM_RDATA = '0;
    model_reset();
    #2 nRST = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge CLK);
    #1 nRST = 1'b1;
    bus.IMEM_GRANT = 1'b1;

    // Streaming start with immediate grant and single-cycle latency.
    repeat (2) step();
    bus.EN = 1'b1;
    repeat (20) step();

    // Stall window with longer memory latency.
    lat = 3;
    repeat (6) step();
    bus.STALL = 1'b1;
    repeat (5) step();
    bus.STALL = 1'b0;
    repeat (12) step();

    // Redirect with two reads in flight.
    n = 0;
    while (pipe.size() < 2 && n < 20) begin step(); n++; end
    check_eq("br_two_inflight_reached", (pipe.size() >= 2), 1'b1);
    bus.BR_PC = 16'h0040;
    bus.BR_EN = 1'b1;
    step();
    bus.BR_EN = 1'b0;
    repeat (15) step();

    // Redirect coinciding with a grant and a response, under stall.
    lat = 1;
    n = 0;
    while (!(bus.IMEM_REQ && bus.IMEM_RVALID) && n < 20) begin step(); n++; end
    check_eq("br_same_cycle_reached", bus.IMEM_REQ && bus.IMEM_RVALID, 1'b1);
    bus.IMEM_GRANT = 1'b1;
    bus.STALL      = 1'b1;
    bus.BR_PC      = 16'h0100;
    bus.BR_EN      = 1'b1;
    step();
    bus.BR_EN = 1'b0;
    bus.STALL = 1'b0;
    repeat (10) step();

    // Fetch PC wraps past the top of the address space.
    bus.BR_PC = 16'hFFFE;
    bus.BR_EN = 1'b1;
    step();
    bus.BR_EN = 1'b0;
    repeat (12) step();

    // Mixed random traffic.
    gnt_pct = 70;
    repeat (300) begin
      if ($urandom_range(9) == 0) lat = $urandom_range(3, 1);
      bus.STALL = ($urandom_range(99) < 30);
      bus.EN    = ($urandom_range(99) < 92);
      bus.BR_EN = ($urandom_range(99) < 5);
      bus.BR_PC = 16'($urandom);
      step();
    end
    bus.BR_EN = 1'b0;
    bus.STALL = 1'b0;

    // Drain: drop EN with reads outstanding, wait for IDLE.
    bus.EN  = 1'b1;
    gnt_pct = 100;
    lat     = 2;
    n = 0;
    while (pipe.size() < 2 && n < 20) begin step(); n++; end
    bus.EN = 1'b0;
    n = 0;
    while (!bus.IDLE && n < 30) begin step(); n++; end
    check_eq("drain_idle", bus.IDLE, 1'b1);
    repeat (4) step();

    // Asynchronous reset in the middle of a burst.
    bus.EN = 1'b1;
    lat    = 3;
    repeat (7) step();
    #2 nRST = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    bus.IMEM_RVALID = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtsp_if_fetch.md
Name: mtsp_if_fetch

Overview:
- Instruction fetch stage of the Meitner MTSP core; the transmitter that feeds the decode stage ID_0.
- Maintains the fetch PC, issues 128-bit bundle reads to instruction memory, and buffers returned bundles in a small prefetch FIFO.
- Each cycle it presents one registered {PC, UINSTx4} pair to ID_0, or a bubble (all-ones UINSTx4).
- Handles downstream stall, branch redirect with discard of in-flight responses, and start/drain control.

Parameters:
- PC_WIDTH, 16, fetch PC width; PC counts 128-bit bundles.
- FIFO_DEPTH, 2, prefetch entries; power of 2, at least 2.
- BOOT_PC, 0, fetch PC loaded on reset.

Ports:
- CLK  in  1  main clock.
- nRST  in  1  reset, asynchronous, active low.
- EN  in  1  run enable; rise starts fetch, fall starts drain.
- STALL  in  1  downstream hold; outputs must not change.
- BR_EN  in  1  redirect strobe, one cycle.
- BR_PC  in  PC_WIDTH  redirect target.
- IMEM_REQ  out  1  read request.
- IMEM_ADDR  out  PC_WIDTH  bundle address.
- IMEM_GRANT  in  1  request accepted this cycle.
- IMEM_RVALID  in  1  read data valid; in order, latency ≥1.
- IMEM_RDATA  in  128  {p0_m, p0_s, p1_m, p1_s}, 32 bits each.
- PC_OUT  out  PC_WIDTH  PC of the bundle at UINSTx4_OUT.
- UINSTx4_OUT  out  128  bundle to ID_0; all-ones = bubble.
- IDLE  out  1  FSM in S_IDLE, no requests outstanding.

Behaviour:
Reset:
- PC_OUT=0, UINSTx4_OUT=128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, IMEM_REQ=0, IMEM_ADDR=BOOT_PC, IDLE=1.
- FIFO empty; outstanding count and discard count are 0.
- Reset mid-operation aborts everything. Late responses arriving after reset are dropped, because outstanding=0.

FSM:
- S_IDLE -> S_RUN when EN=1.
- S_RUN -> S_DRAIN when EN=0.
- S_DRAIN -> S_IDLE when outstanding=0.
- S_DRAIN -> S_RUN when EN=1.

Request issue:
- IMEM_REQ=1 only in S_RUN, and only when fifo_count + outstanding < FIFO_DEPTH.
- IMEM_ADDR = fetch PC, held stable while REQ=1 and GRANT=0.
- A grant increments outstanding and advances fetch PC by 1; the PC wraps modulo 2^PC_WIDTH.

Response:
- IMEM_RVALID decrements outstanding.
- If discard>0, the data is dropped and discard is decremented; otherwise it is pushed into the FIFO with its PC.
- The FIFO never overflows, guaranteed by the issue rule.
- GRANT and RVALID in the same cycle: the outstanding count is net unchanged.

Output, updated on a cycle with STALL=0 and BR_EN=0:
- FIFO non-empty: pop, and register PC/bundle into PC_OUT/UINSTx4_OUT.
- FIFO empty: UINSTx4_OUT=all-ones, PC_OUT holds.
- A response is pushed and popped through the same cycle only via the FIFO; bypass is not allowed, so latency from RVALID to output is 1 cycle minimum.

STALL=1, BR_EN=0:
- Outputs and FIFO read side hold.
- Issue and response continue, subject to the issue rule.

Redirect, BR_EN=1 (priority over STALL and EN):
- Flush the FIFO; fetch PC <= BR_PC.
- discard <= outstanding after this cycle's grant/response accounting. A grant in the same cycle is discarded; a valid response in the same cycle is dropped.
- Next cycle: UINSTx4_OUT=all-ones even if STALL=1; PC_OUT holds.
- The first request to BR_PC is issued no earlier than the cycle after BR_EN.

Counters:
- outstanding and discard are clog2(FIFO_DEPTH)+1 bits wide.
- IDLE = (state==S_IDLE) && outstanding==0.

Decomposition:
- Shared package (MTSP_Defines):
  - UINST width 32 and UINSTx4 width 128.
  - UINSTx4_BUBBLE all-ones constant.
  - Fetch FSM state enum {S_IDLE, S_RUN, S_DRAIN}.
- One sub-module, mtsp_if_fifo:
  - Synchronous FIFO of {PC, bundle}, FIFO_DEPTH entries.
  - Ports: push, pop, flush, empty, count.
  - Pointer wrap via extra MSB.
- The top level holds the FSM, counters, request logic and output register.

Test Plan:
- Reset, then EN=1 with memory granting immediately and latency 1 -> IMEM_ADDR 0,1,2,…; outputs PC_OUT 0,1,2 with matching RDATA; the first bubble cycles are all-ones; back-to-back, no gaps after fill.
- STALL=1 for 5 cycles mid-stream with latency 3 -> outputs frozen; outstanding+fifo never exceeds 2; no data lost; sequence resumes at the next PC.
- BR_EN with BR_PC=0x0040 while 2 requests are in flight -> both responses dropped; next output is a bubble; first valid PC_OUT=0x0040.
- BR_EN on the same cycle as GRANT and as RVALID -> both killed; discard count correct; no stale bundle is ever output.
- Fetch PC=0xFFFF with PC_WIDTH=16 -> next IMEM_ADDR=0x0000.
- EN drops with 2 outstanding -> REQ=0 immediately; IDLE rises the cycle after the last RVALID; nRST asserted mid-burst -> all outputs at reset values asynchronously.
